// File: rtl/adder_pkg.sv
// Shared types and configuration helpers for the pipelined adder.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int unsigned DEFAULT_WIDTH  = 32;
    localparam int unsigned DEFAULT_STAGES = 4;
    localparam int unsigned MIN_STAGES     = 1;

    function automatic bit cfg_legal(int unsigned width, int unsigned stages);
        return (stages >= MIN_STAGES) && (width >= stages) && ((width % stages) == 0);
    endfunction

    // Guarded so an illegal STAGES=0 reaches the fatal check instead of dividing by zero.
    function automatic int unsigned chunk_width(int unsigned width, int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

endpackage

// File: rtl/adder_stage.sv
// One pipeline slice: CHUNK-bit combinational add with carry in and carry out.
module adder_stage #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out
);

    logic [CHUNK:0] total;

    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c_in};
    end

    assign sum   = total[CHUNK-1:0];
    assign c_out = total[CHUNK];

endmodule

// File: rtl/pipelined_adder.sv
// Carry-skewed pipelined adder/subtractor with valid/ready handshake on both sides.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  op_e              op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

    if (!cfg_legal(WIDTH, STAGES)) begin : g_cfg_check
        $fatal(1, "pipelined_adder: illegal WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
    end

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] carry_q;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];

    logic [STAGES-1:0] load;
    logic [STAGES-1:0] src_valid;
    logic [STAGES-1:0] src_carry;
    logic [STAGES-1:0] chunk_carry;
    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  src_sum [STAGES];
    logic [WIDTH-1:0]  sum_d   [STAGES];
    logic [CHUNK-1:0]  chunk_sum [STAGES];

    logic [WIDTH-1:0]  b_eff;
    logic              carry_eff;

    // Subtraction folds into addition: a + ~b + !borrow_in.
    assign b_eff     = (op == OP_SUB) ? ~b : b;
    assign carry_eff = (op == OP_SUB) ? ~c_in : c_in;

    // Stage k is fed by stage k-1; stage 0 by the input port.
    always_comb begin
        src_valid[0] = in_valid;
        src_a[0]     = a;
        src_b[0]     = b_eff;
        src_sum[0]   = '0;
        src_carry[0] = carry_eff;
        for (int k = 1; k < int'(STAGES); k++) begin
            src_valid[k] = valid_q[k-1];
            src_a[k]     = a_q[k-1];
            src_b[k]     = b_q[k-1];
            src_sum[k]   = sum_q[k-1];
            src_carry[k] = carry_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_stage #(
            .CHUNK (CHUNK)
        ) u_adder_stage (
            .a     (src_a[k][k*CHUNK +: CHUNK]),
            .b     (src_b[k][k*CHUNK +: CHUNK]),
            .c_in  (src_carry[k]),
            .sum   (chunk_sum[k]),
            .c_out (chunk_carry[k])
        );
    end

    // Finished chunks below k pass through; chunk k is filled in by this stage.
    always_comb begin
        for (int k = 0; k < int'(STAGES); k++) begin
            sum_d[k] = src_sum[k];
            sum_d[k][k*CHUNK +: CHUNK] = chunk_sum[k];
        end
    end

    // A stage loads when empty or when everything downstream of it moves (bubble collapse).
    always_comb begin
        logic downstream_ready;
        downstream_ready = out_ready;
        load = '0;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            load[k]          = !valid_q[k] || downstream_ready;
            downstream_ready = load[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (load[k]) begin
                    valid_q[k] <= src_valid[k];
                    if (src_valid[k]) begin
                        a_q[k]     <= src_a[k];
                        b_q[k]     <= src_b[k];
                        sum_q[k]   <= sum_d[k];
                        carry_q[k] <= chunk_carry[k];
                    end
                end
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign c_out     = carry_q[STAGES-1];
    assign overflow  = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
                       (sum_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed checks of the pipelined adder (16-bit/4-stage and 8-bit/1-stage) plus a scoreboard run.
module tb_pipelined_adder;
    import adder_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    op_e         op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        c_out;
    logic        overflow;

    logic        in_valid1;
    logic        in_ready1;
    logic [7:0]  a1;
    logic [7:0]  b1;
    logic        c_in1;
    op_e         op1;
    logic        out_valid1;
    logic        out_ready1;
    logic [7:0]  sum1;
    logic        c_out1;
    logic        overflow1;

    int total = 0;
    int bad   = 0;

    pipelined_adder #(
        .WIDTH  (16),
        .STAGES (4)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .overflow  (overflow)
    );

    pipelined_adder #(
        .WIDTH  (8),
        .STAGES (1)
    ) u_dut_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .c_in      (c_in1),
        .op        (op1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .c_out     (c_out1),
        .overflow  (overflow1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Result as {overflow, c_out, sum} from the arithmetic definition.
    function automatic logic [17:0] model(op_e o, logic [15:0] x, logic [15:0] y, logic ci);
        logic [15:0] ye;
        logic        ce;
        logic [16:0] t;
        logic        ov;
        ye = (o == OP_SUB) ? ~y : y;
        ce = (o == OP_SUB) ? ~ci : ci;
        t  = {1'b0, x} + {1'b0, ye} + {16'b0, ce};
        ov = (x[15] == ye[15]) && (t[15] != x[15]);
        return {ov, t};
    endfunction

    task automatic send_one(input string tag, input op_e o, input logic [15:0] ia,
                            input logic [15:0] ib, input logic ic, input logic [15:0] es,
                            input logic ec, input logic eo);
        op = o; a = ia; b = ib; c_in = ic; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, "_rdy"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check({tag, "_lat"}, out_valid, 0);
            step();
        end
        check({tag, "_vld"}, out_valid, 1);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, c_out, ec);
        check({tag, "_ovf"}, overflow, eo);
    endtask

    logic [15:0] vec_a   [8] = '{16'h0001, 16'h00FF, 16'h0FFF, 16'hFFFF,
                                 16'h1234, 16'h8000, 16'h4000, 16'hABCD};
    logic [15:0] vec_b   [8] = '{16'h0001, 16'h0001, 16'h0001, 16'hFFFF,
                                 16'h4321, 16'h8000, 16'h4000, 16'h1111};
    logic [15:0] vec_s   [8] = '{16'h0002, 16'h0100, 16'h1000, 16'hFFFE,
                                 16'h5555, 16'h0000, 16'h8000, 16'hBCDE};
    logic        vec_c   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        vec_o   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] bp_exp  [5] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055};

    initial begin
        logic [17:0] exp_q [$];
        logic [17:0] e;
        int sent;
        int recv;
        int cyc;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; op = OP_ADD; out_ready = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; c_in1 = 1'b0; op1 = OP_ADD; out_ready1 = 1'b1;
        #12;
        check("reset_out_valid", out_valid, 0);
        check("reset_sum", sum, 0);
        check("reset_c_out", c_out, 0);
        check("reset_overflow", overflow, 0);
        check("reset_in_ready", in_ready, 1);
        rst = 1'b0;

        // Single beats, including carry through every chunk and signed overflow cases.
        send_one("add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        send_one("sub_ovf", OP_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        send_one("sub_neg", OP_SUB, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        send_one("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        send_one("add_cin", OP_ADD, 16'h00FF, 16'h0F00, 1'b1, 16'h1000, 1'b0, 1'b0);
        send_one("sub_bin", OP_SUB, 16'h1000, 16'h0001, 1'b1, 16'h0FFE, 1'b1, 1'b0);
        step();

        // Eight back-to-back adds: results on eight consecutive cycles.
        op = OP_ADD; c_in = 1'b0; out_ready = 1'b1;
        for (int t = 0; t < 11; t++) begin
            if (t < 8) begin
                a = vec_a[t]; b = vec_b[t]; in_valid = 1'b1;
                #1;
                check("b2b_rdy", in_ready, 1);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (t == 2) check("b2b_early", out_valid, 0);
            if (t >= 3) begin
                check("b2b_vld", out_valid, 1);
                check("b2b_sum", sum, vec_s[t-3]);
                check("b2b_cout", c_out, vec_c[t-3]);
                check("b2b_ovf", overflow, vec_o[t-3]);
            end
        end
        in_valid = 1'b0;
        step();
        check("b2b_drained", out_valid, 0);

        // Backpressure: fill all four stages, stall three cycles, then release.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 16'h0010 * 16'(i + 1); b = 16'(i + 1); in_valid = 1'b1;
            #1;
            check("bp_fill_rdy", in_ready, 1);
            step();
        end
        a = 16'h0050; b = 16'h0005;
        #1;
        check("bp_full_rdy", in_ready, 0);
        check("bp_full_vld", out_valid, 1);
        check("bp_full_sum", sum, bp_exp[0]);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_sum", sum, bp_exp[0]);
            check("bp_hold_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", in_ready, 1);
        step();
        in_valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            check("bp_drain_vld", out_valid, 1);
            check("bp_drain_sum", sum, bp_exp[i]);
            step();
        end
        check("bp_drain_empty", out_valid, 0);

        // Asynchronous reset with beats in flight.
        for (int i = 0; i < 4; i++) begin
            a = 16'h0100 * 16'(i + 1); b = 16'h0001; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check("rst_pre_vld", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_vld", out_valid, 0);
        check("rst_async_sum", sum, 0);
        check("rst_async_rdy", in_ready, 1);
        step();
        #3;
        rst = 1'b0;
        send_one("post_rst", OP_ADD, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_stale", out_valid, 0);
        end

        // Single-stage build: registered adder with latency 1.
        a1 = 8'hF0; b1 = 8'h20; op1 = OP_ADD; in_valid1 = 1'b1;
        #1;
        check("s1_rdy", in_ready1, 1);
        step();
        in_valid1 = 1'b0;
        check("s1_vld", out_valid1, 1);
        check("s1_sum", sum1, 8'h10);
        check("s1_cout", c_out1, 1);
        check("s1_ovf", overflow1, 0);
        step();
        check("s1_empty", out_valid1, 0);

        // Random traffic against the arithmetic model.
        sent = 0; recv = 0; cyc = 0;
        while (recv < 300 && cyc < 5000) begin
            if (sent < 300 && $urandom_range(0, 3) != 0) begin
                a = 16'($urandom()); b = 16'($urandom());
                c_in = 1'($urandom_range(0, 1)); op = op_e'($urandom_range(0, 1));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(op, a, b, c_in));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_extra_beat", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_result", {14'b0, overflow, c_out, sum}, {14'b0, e});
                end
                recv++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        check("rnd_beats_received", recv, 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
